// File: rtl/po_pkg.sv
// Shared definitions for the parallel output port: register offsets within
// a channel's four-address window and the per-channel handshake states.
package po_pkg;

    localparam logic [1:0] OFS_WR  = 2'd0;
    localparam logic [1:0] OFS_SET = 2'd1;
    localparam logic [1:0] OFS_CLR = 2'd2;
    localparam logic [1:0] OFS_TGL = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ch_state_e;

endpackage

// File: rtl/po_channel.sv
// One output channel: holds the output value, runs the strobe/ack handshake
// and keeps a sticky overrun flag for writes that arrive while pending.
module po_channel
    import po_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_hit,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ovr_clr,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe,
    output logic              busy,
    output logic              overrun
);

    ch_state_e         state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              ovr_reg, ovr_next;
    logic [DATA_W-1:0] new_val;

    // Candidate value produced by the addressed bitwise operation.
    always_comb begin
        new_val = wdata;
        case (op)
            OFS_WR:  new_val = wdata;
            OFS_SET: new_val = data_reg | wdata;
            OFS_CLR: new_val = data_reg & ~wdata;
            OFS_TGL: new_val = data_reg ^ wdata;
            default: new_val = wdata;
        endcase
    end

    // Handshake next-state; a write while pending is dropped and flagged,
    // and a fresh overrun beats a same-cycle clear.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        ovr_next   = ovr_reg & ~ovr_clr;
        case (state_reg)
            IDLE: begin
                if (wr_hit) begin
                    data_next  = new_val;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (wr_hit) begin
                    ovr_next = 1'b1;
                end
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, output value and overrun flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign data_out = data_reg;
    assign strobe   = (state_reg == PEND);
    assign busy     = (state_reg == PEND);
    assign overrun  = ovr_reg;

endmodule

// File: rtl/parallel_out_port.sv
// Memory-mapped multi-channel parallel output port: address decode, status
// register assembly and registered readback around NUM_CH channels.
module parallel_out_port
    import po_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hE0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     EN,
    input  logic                     RdEn,
    input  logic [ADDR_W-1:0]        Address,
    input  logic [DATA_W-1:0]        RegData,
    output logic [DATA_W-1:0]        RdData,
    output logic [NUM_CH*DATA_W-1:0] DataOut,
    output logic [NUM_CH-1:0]        Strobe,
    input  logic [NUM_CH-1:0]        Ack
);

    localparam int                CH_W        = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + ADDR_W'(4 * NUM_CH);

    logic [ADDR_W-1:0] rel;
    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        op;
    logic              in_chan;
    logic              status_hit;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] ovr_clr;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] overrun;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;

    // Offset from the base splits into channel index and operation.
    assign rel        = Address - BASE_ADDR;
    assign ch_sel     = rel[ADDR_W-1:2];
    assign op         = rel[1:0];
    assign in_chan    = (Address >= BASE_ADDR) && (Address < STATUS_ADDR);
    assign status_hit = (Address == STATUS_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_hit[gi]  = EN && in_chan && (ch_sel == CH_W'(gi));
            assign ovr_clr[gi] = EN && status_hit && RegData[NUM_CH + gi];

            po_channel #(
                .DATA_W (DATA_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .wr_hit   (wr_hit[gi]),
                .op       (op),
                .wdata    (RegData),
                .ovr_clr  (ovr_clr[gi]),
                .ack      (Ack[gi]),
                .data_out (ch_data[gi]),
                .strobe   (Strobe[gi]),
                .busy     (busy[gi]),
                .overrun  (overrun[gi])
            );

            assign DataOut[gi*DATA_W +: DATA_W] = ch_data[gi];
        end
    endgenerate

    // Status layout: busy in the low NUM_CH bits, overrun above, rest zero.
    always_comb begin
        status_word                       = '0;
        status_word[NUM_CH-1:0]           = busy;
        status_word[2*NUM_CH-1:NUM_CH]    = overrun;
    end

    // Read mux; misses and idle cycles return zero.
    always_comb begin
        rd_data_next = '0;
        if (RdEn) begin
            if (in_chan) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == CH_W'(i)) begin
                        rd_data_next = ch_data[i];
                    end
                end
            end else if (status_hit) begin
                rd_data_next = status_word;
            end
        end
    end

    // Registered read data, sampled from pre-write state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign RdData = rd_data_reg;

endmodule

// File: tb/tb_parallel_out_port.sv
// Bench for parallel_out_port: a table of bus cycles with the outputs
// expected after each clock edge, scored through a queue, plus hand-written
// reset sequences.
module tb_parallel_out_port;

    logic        clk;
    logic        rst;
    logic        EN;
    logic        RdEn;
    logic [7:0]  Address;
    logic [7:0]  RegData;
    logic [7:0]  RdData;
    logic [31:0] DataOut;
    logic [3:0]  Strobe;
    logic [3:0]  Ack;

    parallel_out_port dut (
        .clk     (clk),
        .rst     (rst),
        .EN      (EN),
        .RdEn    (RdEn),
        .Address (Address),
        .RegData (RegData),
        .RdData  (RdData),
        .DataOut (DataOut),
        .Strobe  (Strobe),
        .Ack     (Ack)
    );

    typedef struct {
        logic        en;
        logic        rden;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [3:0]  ack;
        logic [31:0] exp_do;
        logic [3:0]  exp_str;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] exp_do;
        logic [3:0]  exp_str;
        logic [7:0]  exp_rd;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic en, input logic rden, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [3:0] ack,
                       input logic [31:0] exp_do, input logic [3:0] exp_str,
                       input logic [7:0] exp_rd);
        vec_t v;
        v.en = en; v.rden = rden; v.addr = addr; v.wdata = wdata; v.ack = ack;
        v.exp_do = exp_do; v.exp_str = exp_str; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    // Drive one bus cycle at the falling edge, then score after the rising edge.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        EN = v.en; RdEn = v.rden; Address = v.addr; RegData = v.wdata; Ack = v.ack;
        e.idx = idx; e.exp_do = v.exp_do; e.exp_str = v.exp_str; e.exp_rd = v.exp_rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check($sformatf("v%0d DataOut", got.idx), DataOut, got.exp_do);
        check($sformatf("v%0d Strobe", got.idx), {28'd0, Strobe}, {28'd0, got.exp_str});
        check($sformatf("v%0d RdData", got.idx), {24'd0, RdData}, {24'd0, got.exp_rd});
        $display("cycle v%0d en=%0b rd=%0b addr=%h data=%h ack=%b -> DataOut=%h Strobe=%b RdData=%h",
                 idx, v.en, v.rden, v.addr, v.wdata, v.ack, DataOut, Strobe, RdData);
    endtask

    task automatic idle_inputs();
        EN = 1'b0; RdEn = 1'b0; Address = 8'h00; RegData = 8'h00; Ack = 4'h0;
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset DataOut", DataOut, 32'h0);
        check("reset Strobe", {28'd0, Strobe}, 32'h0);
        check("reset RdData", {24'd0, RdData}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        //   en    rden  addr   wdata  ack      DataOut        Strobe   RdData
        // ch0 write, ack, readback
        add(1'b1, 1'b0, 8'hE0, 8'h5A, 4'b0000, 32'h0000_005A, 4'b0001, 8'h00);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0001, 32'h0000_005A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hE0, 8'h00, 4'b0000, 32'h0000_005A, 4'b0000, 8'h5A);
        // ch1 write/set/clear/toggle
        add(1'b1, 1'b0, 8'hE4, 8'hF0, 4'b0000, 32'h0000_F05A, 4'b0010, 8'h00);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0010, 32'h0000_F05A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hE5, 8'h0F, 4'b0000, 32'h0000_FF5A, 4'b0010, 8'h00);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0010, 32'h0000_FF5A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hE6, 8'h3C, 4'b0000, 32'h0000_C35A, 4'b0010, 8'h00);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0010, 32'h0000_C35A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hE7, 8'hFF, 4'b0000, 32'h0000_3C5A, 4'b0010, 8'h00);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0010, 32'h0000_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hE5, 8'h00, 4'b0000, 32'h0000_3C5A, 4'b0000, 8'h3C);
        // ch2 overrun while pending, then write-1-to-clear
        add(1'b1, 1'b0, 8'hE8, 8'h11, 4'b0000, 32'h0011_3C5A, 4'b0100, 8'h00);
        add(1'b1, 1'b0, 8'hE8, 8'h22, 4'b0000, 32'h0011_3C5A, 4'b0100, 8'h00);
        add(1'b0, 1'b1, 8'hF0, 8'h00, 4'b0000, 32'h0011_3C5A, 4'b0100, 8'h44);
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b0100, 32'h0011_3C5A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hF0, 8'h40, 4'b0000, 32'h0011_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hF0, 8'h00, 4'b0000, 32'h0011_3C5A, 4'b0000, 8'h00);
        // ch3 write colliding with ack: ack wins, write dropped and flagged
        add(1'b1, 1'b0, 8'hEC, 8'h55, 4'b0000, 32'h5511_3C5A, 4'b1000, 8'h00);
        add(1'b1, 1'b0, 8'hEC, 8'hAA, 4'b1000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hF0, 8'h00, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h80);
        // out-of-map writes and reads
        add(1'b1, 1'b0, 8'h7F, 8'hFF, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hFF, 8'hFF, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hDF, 8'hFF, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'h7F, 8'h00, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hFF, 8'h00, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hF1, 8'h00, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b1, 1'b0, 8'hF0, 8'h80, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        add(1'b0, 1'b1, 8'hF0, 8'h00, 4'b0000, 32'h5511_3C5A, 4'b0000, 8'h00);
        // ack in idle is ignored
        add(1'b0, 1'b0, 8'h00, 8'h00, 4'b1111, 32'h5511_3C5A, 4'b0000, 8'h00);
        // simultaneous write and read shows the pre-write value
        add(1'b1, 1'b1, 8'hE0, 8'h99, 4'b0000, 32'h5511_3C99, 4'b0001, 8'h5A);
        add(1'b0, 1'b1, 8'hE3, 8'h00, 4'b0000, 32'h5511_3C99, 4'b0001, 8'h99);
        add(1'b0, 1'b1, 8'hF0, 8'h00, 4'b0001, 32'h5511_3C99, 4'b0000, 8'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        // Reset in the middle of a handshake with an overrun pending.
        v.en = 1'b1; v.rden = 1'b1; v.addr = 8'hE4; v.wdata = 8'h77; v.ack = 4'b0000;
        v.exp_do = 32'h5511_7799; v.exp_str = 4'b0010; v.exp_rd = 8'h3C;
        step(100, v);
        v.en = 1'b1; v.rden = 1'b1; v.addr = 8'hE4; v.wdata = 8'h12; v.ack = 4'b0000;
        v.exp_do = 32'h5511_7799; v.exp_str = 4'b0010; v.exp_rd = 8'h77;
        step(101, v);
        v.en = 1'b0; v.rden = 1'b1; v.addr = 8'hF0; v.wdata = 8'h00; v.ack = 4'b0000;
        v.exp_do = 32'h5511_7799; v.exp_str = 4'b0010; v.exp_rd = 8'h22;
        step(102, v);
        #2;
        rst = 1'b0;
        #1;
        check("midreset DataOut", DataOut, 32'h0);
        check("midreset Strobe", {28'd0, Strobe}, 32'h0);
        check("midreset RdData", {24'd0, RdData}, 32'h0);
        $display("cycle midreset -> DataOut=%h Strobe=%b RdData=%h", DataOut, Strobe, RdData);
        @(negedge clk);
        idle_inputs();
        @(negedge clk) rst = 1'b1;
        v.en = 1'b0; v.rden = 1'b1; v.addr = 8'hF0; v.wdata = 8'h00; v.ack = 4'b0000;
        v.exp_do = 32'h0; v.exp_str = 4'b0000; v.exp_rd = 8'h00;
        step(103, v);
        v.en = 1'b0; v.rden = 1'b1; v.addr = 8'hE4; v.wdata = 8'h00; v.ack = 4'b0000;
        v.exp_do = 32'h0; v.exp_str = 4'b0000; v.exp_rd = 8'h00;
        step(104, v);

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
